mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter CACHE_WORDS, default 2048: word depth of the shared L1 cache array.
REQ-002 SHALL have parameter ART_BASE, default 64'h2000: JTAG UART data register byte address.
REQ-003 SHALL have parameter KEY_BASE, default 64'h2004: keyboard data register byte address.
REQ-004 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch is pending.
REQ-005 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all logic on rising edge (one clock; reset is asynchronous and active-low)
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  instruction fetch request, held until if_ack
- if_addr  in  64  fetch byte address
- if_ack  out  1  one-cycle fetch completion pulse
- if_instr  out  32  byte-swapped instruction, valid with if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  64  data byte address
- d_wdata  in  64  write data, low 32 bits used
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  64  read data, valid with d_ack
- d_err  out  1  unmapped-address pulse, coincident with d_ack
- mem_addr  out  11  cache word address
- mem_we  out  1  cache write enable
- mem_wdata  out  32  cache write data
- mem_rdata  in  32  cache read data, one-cycle synchronous latency
- art_wr  out  1  one-cycle UART write strobe
- art_data  out  32  UART write data
- key_strobe  in  1  one-cycle new-key pulse
- key_ascii  in  8  ASCII code, valid with key_strobe

Function
REQ-006 States: IDLE, ACCESS, RESP; IDLE->ACCESS when a request is granted; ACCESS->RESP always; RESP->IDLE always.
REQ-007 Grant in IDLE: data wins over fetch, except the fetch wins when starve_cnt == STARVE_MAX.
REQ-008 starve_cnt increments on each data grant while if_req=1, clears on every fetch grant, and saturates at STARVE_MAX.
REQ-009 Address, op and write data SHALL be latched at grant; later changes on the requester inputs are ignored until ack.
REQ-010 Latency: request sampled in IDLE at cycle N -> ack at cycle N+2; best-case throughput one transaction per 3 cycles.
REQ-011 Decode: byte addr < CACHE_WORDS*4 is cache, ART_BASE is UART, KEY_BASE is keyboard; anything else is unmapped.
REQ-012 Cache word address = addr[12:2]; addr[1:0] ignored (no misalignment trap).
REQ-013 Cache read: mem_addr driven in ACCESS; mem_rdata captured in RESP.
REQ-014 Cache write: mem_we=1 in ACCESS only, with mem_wdata = d_wdata[31:0].
REQ-015 Fetch result: if_instr = {r[7:0], r[15:8], r[23:16], r[31:24]} of the word read.
REQ-016 Data cache read: d_rdata = {32'd0, word}.
REQ-017 Fetch from UART, keyboard or an unmapped address: if_instr = 32'h00000013 (NOP).
REQ-018 UART write: art_wr=1 for exactly the ACCESS cycle, art_data = d_wdata[31:0]; UART read returns 0.
REQ-019 Keyboard buffer: key_strobe loads key_buf and sets key_valid.
REQ-020 Keyboard read returns {55'd0, key_valid, key_buf} and clears key_valid in ACCESS.
REQ-021 If key_strobe and a keyboard read occur in the same cycle, the read returns the old value and the new key is latched with key_valid=1.
REQ-022 A key_strobe while key_valid=1 overwrites key_buf (no queue).
REQ-023 Writes to KEY_BASE are acked with no effect.
REQ-024 Unmapped data access: no memory or UART side effect, d_rdata=0, d_err=1 with d_ack.
REQ-025 if_ack and d_ack are never high in the same cycle; mem_we is never high outside ACCESS.
REQ-026 A request deasserted before its ack still completes; the ack is still issued.

Reset
REQ-027 While reset_n=0, immediately: state=IDLE, starve_cnt=0, key_valid=0, key_buf=0, all ack/strobe/we/err outputs 0, data outputs 0.
REQ-028 Reset mid-transaction aborts it with no ack; the first request is sampled on the first clk edge after reset_n rises.

Structure
REQ-029 The shared header SHALL hold the state encoding and the default base constants (cache size, ART_BASE, KEY_BASE, NOP encoding).
REQ-030 The keyboard buffer SHALL be one sub-module, key_latch; all other logic stays flat.

Verification
REQ-031 Cache word 3 = 32'h93001000, fetch at 0xC -> if_ack 2 cycles later with if_instr=32'h00100093.
REQ-032 d_req and if_req raised in the same cycle -> d_ack first, if_ack 3 cycles later.
REQ-033 Continuous d_req with if_req held -> fetch granted after exactly 4 data grants.
REQ-034 Write 0x41 to 0x2000 -> single-cycle art_wr with art_data=0x41 and no mem_we.
REQ-035 key_strobe 0x61, then read 0x2004 -> d_rdata=0x161; second read -> 0x061.
REQ-036 Read 0x3000 -> d_err=1, d_rdata=0; reset_n pulsed in ACCESS -> no ack and all outputs 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encoding, address map defaults and helpers
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        RG_CACHE = 2'd0,
        RG_ART   = 2'd1,
        RG_KEY   = 2'd2,
        RG_NONE  = 2'd3
    } region_e;

    localparam int          DEF_CACHE_WORDS = 2048;
    localparam logic [63:0] DEF_ART_BASE    = 64'h2000;
    localparam logic [63:0] DEF_KEY_BASE    = 64'h2004;
    localparam logic [31:0] NOP_INSTR       = 32'h00000013;

    // Cache holds instructions big-endian; the core wants them little-endian.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_key_latch.sv
// rtl/mem_bus_arbiter_key_latch.sv - single-entry keyboard buffer with read-clear
module key_latch
    import mem_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_strobe_i,
    input  logic [7:0] key_ascii_i,
    input  logic       rd_clr_i,
    output logic [7:0] key_buf_o,
    output logic       key_valid_o
);

    logic [7:0] key_buf_q;
    logic       key_valid_q;

    // A new key beats a simultaneous read-clear so the keystroke is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_buf_q   <= 8'd0;
            key_valid_q <= 1'b0;
        end else if (key_strobe_i) begin
            key_buf_q   <= key_ascii_i;
            key_valid_q <= 1'b1;
        end else if (rd_clr_i) begin
            key_valid_q <= 1'b0;
        end
    end

    assign key_buf_o   = key_buf_q;
    assign key_valid_o = key_valid_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter onto shared L1 cache, UART and keyboard
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int          CACHE_WORDS = DEF_CACHE_WORDS,
    parameter logic [63:0] ART_BASE    = DEF_ART_BASE,
    parameter logic [63:0] KEY_BASE    = DEF_KEY_BASE,
    parameter int          STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_instr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic [10:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        art_wr,
    output logic [31:0] art_data,
    input  logic        key_strobe,
    input  logic [7:0]  key_ascii
);

    localparam int          SW          = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [63:0] CACHE_BYTES = 64'(CACHE_WORDS) * 64'd4;

    arb_state_e    state_q;
    region_e       region_q;
    logic          fetch_q;
    logic          we_q;
    logic [SW-1:0] starve_cnt_q;
    logic [63:0]   io_q;

    logic          if_ack_q, d_ack_q, d_err_q, mem_we_q, art_wr_q;
    logic [31:0]   if_instr_q, mem_wdata_q, art_data_q;
    logic [63:0]   d_rdata_q;
    logic [10:0]   mem_addr_q;

    logic          grant_d, grant_f;
    logic [63:0]   sel_addr;
    region_e       sel_region;
    logic          key_rd_clr;
    logic [7:0]    key_buf;
    logic          key_valid;

    wire unused_wdata_hi = &{1'b0, d_wdata[63:32]};

    always_comb begin
        grant_d    = d_req && !(if_req && (starve_cnt_q == STARVE_LIM));
        grant_f    = if_req && !grant_d;
        sel_addr   = grant_d ? d_addr : if_addr;
        sel_region = RG_NONE;
        if (sel_addr < CACHE_BYTES)    sel_region = RG_CACHE;
        else if (sel_addr == ART_BASE) sel_region = RG_ART;
        else if (sel_addr == KEY_BASE) sel_region = RG_KEY;
    end

    assign key_rd_clr = (state_q == ST_ACCESS) && (region_q == RG_KEY) && !we_q && !fetch_q;

    key_latch u_key_latch (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_strobe_i (key_strobe),
        .key_ascii_i  (key_ascii),
        .rd_clr_i     (key_rd_clr),
        .key_buf_o    (key_buf),
        .key_valid_o  (key_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            region_q     <= RG_NONE;
            fetch_q      <= 1'b0;
            we_q         <= 1'b0;
            starve_cnt_q <= '0;
            io_q         <= 64'd0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            art_wr_q     <= 1'b0;
            if_instr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            art_data_q   <= 32'd0;
            d_rdata_q    <= 64'd0;
            mem_addr_q   <= 11'd0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            d_err_q  <= 1'b0;
            mem_we_q <= 1'b0;
            art_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_d || grant_f) begin
                        state_q    <= ST_ACCESS;
                        fetch_q    <= grant_f;
                        we_q       <= grant_d && d_we;
                        region_q   <= sel_region;
                        mem_addr_q <= sel_addr[12:2];
                        // Side-effect strobes are launched here so they land exactly on ACCESS.
                        if (grant_d && d_we && (sel_region == RG_CACHE)) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= d_wdata[31:0];
                        end
                        if (grant_d && d_we && (sel_region == RG_ART)) begin
                            art_wr_q   <= 1'b1;
                            art_data_q <= d_wdata[31:0];
                        end
                        if (grant_f) begin
                            starve_cnt_q <= '0;
                        end else if (if_req && (starve_cnt_q != STARVE_LIM)) begin
                            starve_cnt_q <= starve_cnt_q + 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                    io_q    <= key_rd_clr ? {55'd0, key_valid, key_buf} : 64'd0;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    if (fetch_q) begin
                        if_ack_q   <= 1'b1;
                        if_instr_q <= (region_q == RG_CACHE) ? byte_swap32(mem_rdata) : NOP_INSTR;
                    end else begin
                        d_ack_q <= 1'b1;
                        d_err_q <= (region_q == RG_NONE);
                        if (region_q == RG_CACHE) d_rdata_q <= we_q ? 64'd0 : {32'd0, mem_rdata};
                        else                      d_rdata_q <= io_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign if_instr  = if_instr_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign art_wr    = art_wr_q;
    assign art_data  = art_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk, reset_n;
    logic        if_req, if_ack, d_req, d_we, d_ack, d_err;
    logic [63:0] if_addr, d_addr, d_wdata, d_rdata;
    logic [31:0] if_instr, mem_wdata, mem_rdata, art_data;
    logic [10:0] mem_addr;
    logic        mem_we, art_wr, key_strobe;
    logic [7:0]  key_ascii;

    logic [31:0] mem [0:2047];
    int n_chk = 0, n_bad = 0;
    int art_cnt = 0, we_cnt = 0, both_cnt = 0;

    mem_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .art_wr(art_wr), .art_data(art_data),
        .key_strobe(key_strobe), .key_ascii(key_ascii)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = {16'hA5A5, 16'(i)};
        mem[3] = 32'h93001000;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (art_wr) art_cnt++;
            if (mem_we) we_cnt++;
            if (if_ack && d_ack) both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lat counts edges after the sampling edge; -1 means no ack within budget.
    task automatic data_xfer(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                             input logic strobe_mid, input logic [7:0] sascii, input logic drop_early,
                             output logic [63:0] rd, output logic er, output int lat);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        lat = -1; rd = '0; er = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0 && drop_early) begin
                d_req = 1'b0; d_we = ~we; d_addr = 64'h3000; d_wdata = '1;
            end
            key_strobe = strobe_mid && (c == 0);
            key_ascii  = sascii;
            if (d_ack) begin lat = c; rd = d_rdata; er = d_err; break; end
        end
        d_req = 1'b0;
    endtask

    task automatic fetch_xfer(input logic [63:0] addr, output logic [31:0] ins, output int lat);
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        lat = -1; ins = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (if_ack) begin lat = c; ins = if_instr; break; end
        end
        if_req = 1'b0;
    endtask

    task automatic key_pulse(input logic [7:0] a);
        @(negedge clk);
        key_strobe = 1'b1; key_ascii = a;
        @(negedge clk);
        key_strobe = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat, a0, w0, dc, fc, nd, acks;
    logic [31:0] ins;

    initial begin
        reset_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        key_strobe = 0; key_ascii = 0;
        #2;
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_d_err", d_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_art_wr", art_wr, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        fetch_xfer(64'hC, ins, lat);
        chk("fetch_c_lat", lat, 2);
        chk("fetch_c_instr", ins, 32'h00100093);

        a0 = art_cnt; w0 = we_cnt;
        data_xfer(1, 64'h40, 64'hFFFF0000_DEADBEEF, 0, 0, 0, rd, er, lat);
        chk("cwr_lat", lat, 2);
        chk("cwr_err", er, 0);
        chk("cwr_we_cnt", we_cnt - w0, 1);
        chk("cwr_art_cnt", art_cnt - a0, 0);
        data_xfer(0, 64'h40, 0, 0, 0, 0, rd, er, lat);
        chk("crd_data", rd, 64'h00000000_DEADBEEF);
        data_xfer(0, 64'h43, 0, 0, 0, 0, rd, er, lat);
        chk("crd_misalign", rd, 64'h00000000_DEADBEEF);

        a0 = art_cnt; w0 = we_cnt;
        data_xfer(1, 64'h2000, 64'h41, 0, 0, 0, rd, er, lat);
        chk("art_wr_cnt", art_cnt - a0, 1);
        chk("art_data", art_data, 32'h41);
        chk("art_no_we", we_cnt - w0, 0);
        data_xfer(0, 64'h2000, 0, 0, 0, 0, rd, er, lat);
        chk("art_rd", rd, 0);

        key_pulse(8'h61);
        data_xfer(0, 64'h2004, 0, 0, 0, 0, rd, er, lat);
        chk("key_rd1", rd, 64'h161);
        data_xfer(0, 64'h2004, 0, 0, 0, 0, rd, er, lat);
        chk("key_rd2", rd, 64'h061);
        data_xfer(1, 64'h2004, 64'h55, 0, 0, 0, rd, er, lat);
        chk("key_wr_ack", lat, 2);
        chk("key_wr_err", er, 0);
        data_xfer(0, 64'h2004, 0, 0, 0, 0, rd, er, lat);
        chk("key_after_wr", rd, 64'h061);
        data_xfer(0, 64'h2004, 0, 1, 8'h62, 0, rd, er, lat);
        chk("key_race_old", rd, 64'h061);
        data_xfer(0, 64'h2004, 0, 0, 0, 0, rd, er, lat);
        chk("key_race_new", rd, 64'h162);
        key_pulse(8'h70);
        key_pulse(8'h71);
        data_xfer(0, 64'h2004, 0, 0, 0, 0, rd, er, lat);
        chk("key_overwrite", rd, 64'h171);

        data_xfer(0, 64'h3000, 0, 0, 0, 0, rd, er, lat);
        chk("unm_rd_err", er, 1);
        chk("unm_rd_data", rd, 0);
        a0 = art_cnt; w0 = we_cnt;
        data_xfer(1, 64'h3000, 64'h77, 0, 0, 0, rd, er, lat);
        chk("unm_wr_err", er, 1);
        chk("unm_wr_fx", (art_cnt - a0) + (we_cnt - w0), 0);

        fetch_xfer(64'h2000, ins, lat);
        chk("fetch_art_nop", ins, 32'h00000013);
        fetch_xfer(64'h3000, ins, lat);
        chk("fetch_unm_nop", ins, 32'h00000013);

        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 64'h40; if_req = 1; if_addr = 64'hC;
        dc = -1; fc = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (d_ack && dc < 0) begin dc = c; d_req = 0; end
            if (if_ack && fc < 0) begin fc = c; ins = if_instr; if_req = 0; end
            if (dc >= 0 && fc >= 0) break;
        end
        d_req = 0; if_req = 0;
        chk("both_d_first", dc, 2);
        chk("both_f_after", fc, 5);
        chk("both_f_instr", ins, 32'h00100093);

        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 64'h40; if_req = 1; if_addr = 64'hC;
        nd = 0; fc = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (d_ack) nd++;
            if (if_ack) begin fc = c; d_req = 0; if_req = 0; break; end
        end
        d_req = 0; if_req = 0;
        chk("starve_grants", nd, 4);
        chk("starve_f_cycle", fc, 14);
        chk("ack_exclusive", both_cnt, 0);

        data_xfer(1, 64'h44, 64'h12345678, 0, 0, 1, rd, er, lat);
        chk("early_drop_ack", lat, 2);
        data_xfer(0, 64'h44, 0, 0, 0, 0, rd, er, lat);
        chk("early_drop_data", rd, 64'h12345678);

        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 64'h48; d_wdata = 64'hCAFE;
        @(posedge clk); #1;
        chk("rst_pre_we", mem_we, 1);
        reset_n = 0; d_req = 0;
        #1;
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_wdata", mem_wdata, 0);
        chk("rst_mid_rdata", d_rdata, 0);
        chk("rst_mid_instr", if_instr, 0);
        chk("rst_mid_art", art_data, 0);
        chk("rst_mid_ack", d_ack, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (d_ack || if_ack) acks++;
        end
        chk("rst_no_ack", acks, 0);
        data_xfer(0, 64'h48, 0, 0, 0, 0, rd, er, lat);
        chk("rst_no_write", rd, 64'hA5A50012);
        data_xfer(0, 64'h2004, 0, 0, 0, 0, rd, er, lat);
        chk("rst_key_clr", rd, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
